avalon_burst_responder: RTL and testbench
=========================================

Name: avalon_burst_responder

Overview:
Avalon-MM burst slave: the responder end of the 64-bit f2h SDRAM ports that framebuffer_write and framebuffer_read drive as masters. It is backed by on-chip RAM. It stands in for the HPS SDRAM port for bring-up and closed-loop benches, and serves as an on-chip tile buffer. It accepts write bursts with per-byte enables and read bursts returned with readdatavalid, and flags protocol violations.

Parameters:
ADDR_BITS, 10, RAM depth = 2**ADDR_BITS 64-bit words; incoming word address is taken modulo depth.
DATA_BITS, 64, data width; byteenable width = DATA_BITS/8.
BURST_BITS, 8, burstcount width.

Ports:
clock  input  1  system clock (clock_50 domain).
reset_n  input  1  synchronous, active-low reset.
address  input  29  word address of first beat, sampled at command acceptance.
burstcount  input  8  beats in burst, 1..255.
waitrequest  output  1  high = command/beat not accepted this cycle.
read  input  1  read command request.
readdata  output  64  read beat data.
readdatavalid  output  1  readdata valid this cycle.
write  input  1  write beat request.
writedata  input  64  write beat data.
byteenable  input  8  per-byte write mask; bit i gates writedata[8i+7:8i].
protocol_error  output  1  sticky violation flag, cleared only by reset.
write_beat_count  output  32  total accepted write beats, wraps at 2**32.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low on reset_n. Reset values: state IDLE, waitrequest 0, readdatavalid 0, readdata 0, protocol_error 0, write_beat_count 0. RAM contents are not cleared.
- Reset mid-burst: aborts immediately. In-flight read beats are dropped, with no readdatavalid after reset. A partially written burst keeps the beats already written.
- Beat acceptance: a beat/command is accepted when (read|write) && !waitrequest.
- IDLE:
  - waitrequest 0.
  - Write accepted: store beat 0 at address[ADDR_BITS-1:0] under byteenable; latch base and burstcount. burstcount==1 stays IDLE; otherwise go WRITE_BURST with remaining = burstcount-1.
  - Read accepted: latch base and count; go READ_BURST.
  - burstcount==0 on any accepted command: treated as 1, protocol_error set.
  - read && write together: write accepted, read ignored, protocol_error set.
- WRITE_BURST:
  - waitrequest 0. address and burstcount inputs are ignored.
  - Each accepted write stores at (base+beat_index) mod depth, then decrements remaining. The last beat returns to IDLE the same cycle.
  - write low: idle beat, no progress.
  - read high in this state: ignored, protocol_error set.
- READ_BURST:
  - waitrequest 1.
  - Issues RAM read addresses (base+i) mod depth on cycles T+1..T+bc, where T is the acceptance cycle.
  - Registered RAM output gives readdatavalid on T+2..T+bc+1, one beat per cycle, contiguous, in order.
  - State is IDLE again at cycle T+bc+1; a new command accepted then has its first beat at T+bc+3, so return streams never overlap.
- Read-during-write: only one state is active at a time, so there are no same-address RAM hazards.
- write_beat_count increments once per accepted write beat, including beat 0.

Optional Feature:
WAITREQ_STALL_EN:
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every cycle. In IDLE and WRITE_BURST, waitrequest = (lfsr[1:0]==2'b00). Stalled beats are not accepted and the master must hold them. READ_BURST timing is unchanged.
- Undefined: waitrequest is constant 0 outside READ_BURST, and no LFSR logic is synthesized.

Decomposition:
- Package rush3d_avalon_pkg: DATA_BITS/BE_BITS/BURST_BITS/AVALON_ADDR_BITS constants, state enum {IDLE, WRITE_BURST, READ_BURST}, LFSR seed constant.
- Sub-module responder_ram: single-clock RAM with a byte-enabled write port, a registered read port and one read/write address, inferred as M10K.
- FSM, counters and error logic live in avalon_burst_responder.

Test Plan:
- Single write then read:
  - Write addr 0x10, bc 1, data 64'h0123_4567_89AB_CDEF, be 8'hFF.
  - Then read addr 0x10, bc 1 → readdatavalid exactly 2 cycles after accept, data matches.
  - write_beat_count = 1.
- Byte enables:
  - Write 64'hFFFF...F with be 8'hFF, then 64'h0 with be 8'h0F to addr 5.
  - Read → 64'hFFFF_FFFF_0000_0000.
- Burst wrap:
  - ADDR_BITS=4; write bc 4 at addr 14 with data 1..4; read bc 4 at addr 14 → beats 1,2,3,4.
  - Read addr 0 → 3.
- Read burst timing:
  - bc 8 accepted at T → waitrequest high T+1..T+8, readdatavalid T+2..T+9 contiguous.
  - Back-to-back read accepted at T+9.
- Violations:
  - read&write asserted in IDLE → write stored, protocol_error=1.
  - burstcount 0 → one beat, flag stays set until reset_n low one cycle.
- Reset mid-read:
  - reset_n low at T+4 of a bc-8 read → no readdatavalid from T+5.
  - waitrequest 0 after release; earlier written data still readable.

Source files
------------

// File: rtl/avalon_burst_responder_pkg.sv
// Shared constants and state type for the Avalon-MM burst responder.
package rush3d_avalon_pkg;

   localparam int unsigned DATA_BITS        = 64;
   localparam int unsigned BE_BITS          = DATA_BITS / 8;
   localparam int unsigned BURST_BITS       = 8;
   localparam int unsigned AVALON_ADDR_BITS = 29;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_BURST,
      READ_BURST
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/avalon_burst_responder_if.sv
// Avalon-MM burst bus between an f2h-style master and the burst responder.
interface avalon_burst_responder_if;
   import rush3d_avalon_pkg::*;

   logic [AVALON_ADDR_BITS-1:0] address;
   logic [BURST_BITS-1:0]       burstcount;
   logic                        waitrequest;
   logic                        read;
   logic [DATA_BITS-1:0]        readdata;
   logic                        readdatavalid;
   logic                        write;
   logic [DATA_BITS-1:0]        writedata;
   logic [BE_BITS-1:0]          byteenable;

   modport master (
      output address, burstcount, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, burstcount, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/avalon_burst_responder_ram.sv
// Single-clock RAM: byte-enabled write, registered read, one shared address.
module responder_ram #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 64
) (
   input  logic            clock,
   input  logic [AW-1:0]   addr,
   input  logic            we,
   input  logic [DW/8-1:0] be,
   input  logic [DW-1:0]   wdata,
   output logic [DW-1:0]   q
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int unsigned i = 0; i < DW/8; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      q <= mem[addr];
   end

endmodule

// File: rtl/avalon_burst_responder.sv
// Avalon-MM burst slave backed by on-chip RAM; flags protocol violations.
// Optional random write-side stalls are enabled by defining WAITREQ_STALL_EN.
module avalon_burst_responder #(
   parameter int unsigned ADDR_BITS  = 10,
   parameter int unsigned DATA_BITS  = 64,
   parameter int unsigned BURST_BITS = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   avalon_burst_responder_if.slave   bus,
   output logic                      protocol_error,
   output logic [31:0]               write_beat_count
);
   import rush3d_avalon_pkg::state_t;
   import rush3d_avalon_pkg::IDLE;
   import rush3d_avalon_pkg::WRITE_BURST;
   import rush3d_avalon_pkg::READ_BURST;
   import rush3d_avalon_pkg::LFSR_SEED;
   import rush3d_avalon_pkg::AVALON_ADDR_BITS;

   state_t                state;
   logic [ADDR_BITS-1:0]  base;
   logic [ADDR_BITS-1:0]  ram_addr;
   logic [BURST_BITS-1:0] bc_lat;
   logic [BURST_BITS-1:0] idx;
   logic [BURST_BITS-1:0] bc_eff;
   logic                  bc_zero;
   logic                  stall;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  rdv;
   logic [DATA_BITS-1:0]  ram_q;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^bus.address[AVALON_ADDR_BITS-1:ADDR_BITS];

`ifdef WAITREQ_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clock) begin
      if (!reset_n) lfsr <= LFSR_SEED;
      else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign bus.waitrequest   = (state == READ_BURST) || stall;
   assign bus.readdatavalid = rdv;
   // RAM output register is not reset, so data is gated to keep readdata zero when idle.
   assign bus.readdata      = rdv ? ram_q : '0;

   assign bc_zero = (bus.burstcount == '0);
   assign bc_eff  = bc_zero ? BURST_BITS'(1) : BURST_BITS'(bus.burstcount);
   assign wr_acc  = bus.write && !bus.waitrequest;
   assign rd_acc  = bus.read && !bus.write && !bus.waitrequest && (state == IDLE);

   assign ram_addr = (state == IDLE) ? bus.address[ADDR_BITS-1:0]
                                     : base + ADDR_BITS'(idx);

   responder_ram #(
      .AW (ADDR_BITS),
      .DW (DATA_BITS)
   ) u_ram (
      .clock (clock),
      .addr  (ram_addr),
      .we    (wr_acc),
      .be    (bus.byteenable),
      .wdata (bus.writedata),
      .q     (ram_q)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state            <= IDLE;
         rdv              <= 1'b0;
         protocol_error   <= 1'b0;
         write_beat_count <= '0;
         base             <= '0;
         bc_lat           <= '0;
         idx              <= '0;
      end else begin
         rdv <= (state == READ_BURST);
         if (wr_acc) write_beat_count <= write_beat_count + 32'd1;

         case (state)
            IDLE: begin
               if (wr_acc) begin
                  base   <= bus.address[ADDR_BITS-1:0];
                  bc_lat <= bc_eff;
                  idx    <= BURST_BITS'(1);
                  if (bc_eff != BURST_BITS'(1)) state <= WRITE_BURST;
                  if (bc_zero || bus.read) protocol_error <= 1'b1;
               end else if (rd_acc) begin
                  base   <= bus.address[ADDR_BITS-1:0];
                  bc_lat <= bc_eff;
                  idx    <= '0;
                  state  <= READ_BURST;
                  if (bc_zero) protocol_error <= 1'b1;
               end
            end

            WRITE_BURST: begin
               if (bus.read) protocol_error <= 1'b1;
               if (wr_acc) begin
                  idx <= idx + 1'b1;
                  if (idx == bc_lat - 1'b1) state <= IDLE;
               end
            end

            READ_BURST: begin
               // One RAM read address issued per cycle; the last one hands back to IDLE.
               idx <= idx + 1'b1;
               if (idx == bc_lat - 1'b1) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_burst_responder.sv
// Directed + randomized bench for avalon_burst_responder against a memory model.
module tb_avalon_burst_responder;

   localparam int unsigned AB    = 4;
   localparam int unsigned DEPTH = 1 << AB;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        protocol_error;
   logic [31:0] write_beat_count;

   avalon_burst_responder_if bus ();

   avalon_burst_responder #(
      .ADDR_BITS  (AB),
      .DATA_BITS  (64),
      .BURST_BITS (8)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .bus              (bus),
      .protocol_error   (protocol_error),
      .write_beat_count (write_beat_count)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [63:0] m_mem [DEPTH];
   logic [31:0] m_wbc;
   logic        m_err;

   logic [63:0] wd [16];
   logic [7:0]  wb [16];
   logic [28:0] rd_a [4];
   logic [7:0]  rd_b [4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      bus.read  = 1'b0;
      bus.write = 1'b0;
      reset_n   = 1'b0;
      tick();
      reset_n   = 1'b1;
      m_wbc     = '0;
      m_err     = 1'b0;
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_perr"}, protocol_error, m_err);
      chk({tag, "_wbc"}, write_beat_count, m_wbc);
   endtask

   // Writes n beats from wd/wb starting at a; optional idle gaps and read-with-write on beat 0.
   task automatic wr_burst(input logic [28:0] a, input logic [7:0] bcf, input int n,
                           input bit gaps, input bit both);
      int k;
      int slot;
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
            bus.write = 1'b0;
            bus.read  = 1'b0;
            tick();
         end
         bus.write      = 1'b1;
         bus.read       = both && (i == 0);
         bus.address    = (i == 0) ? a : 29'($urandom);
         bus.burstcount = (i == 0) ? bcf : 8'($urandom);
         bus.writedata  = wd[i];
         bus.byteenable = wb[i];
         k = 0;
         @(negedge clock);
         while (bus.waitrequest && k < 50) begin
            tick();
            @(negedge clock);
            k++;
         end
         chk("wr_accept_bound", k < 50, 1'b1);
         slot = (int'(a[AB-1:0]) + i) % DEPTH;
         for (int j = 0; j < 8; j++) begin
            if (wb[i][j]) m_mem[slot][8*j +: 8] = wd[i][8*j +: 8];
         end
         m_wbc++;
         if (i == 0 && (bcf == 8'd0 || both)) m_err = 1'b1;
         tick();
      end
      bus.write = 1'b0;
      bus.read  = 1'b0;
   endtask

   // Issues n back-to-back reads from rd_a/rd_b, each at the earliest cycle the slave is idle.
   task automatic read_cmds(input int n);
      int ts [5];
      int eff [4];
      int endc;
      logic        exp_w;
      logic        exp_v;
      logic [63:0] exp_d;
      ts[0] = 0;
      for (int i = 0; i < n; i++) begin
         eff[i]  = (rd_b[i] == 8'd0) ? 1 : int'(rd_b[i]);
         ts[i+1] = ts[i] + eff[i] + 1;
      end
      endc = ts[n-1] + eff[n-1] + 2;
      for (int c = 0; c <= endc; c++) begin
         bus.read  = 1'b0;
         bus.write = 1'b0;
         for (int i = 0; i < n; i++) begin
            if (ts[i] == c) begin
               bus.read       = 1'b1;
               bus.address    = rd_a[i];
               bus.burstcount = rd_b[i];
               if (rd_b[i] == 8'd0) m_err = 1'b1;
            end
         end
         @(negedge clock);
         exp_w = 1'b0;
         exp_v = 1'b0;
         exp_d = '0;
         for (int i = 0; i < n; i++) begin
            if (c >= ts[i] + 1 && c <= ts[i] + eff[i]) exp_w = 1'b1;
            if (c >= ts[i] + 2 && c <= ts[i] + eff[i] + 1) begin
               exp_v = 1'b1;
               exp_d = m_mem[(int'(rd_a[i][AB-1:0]) + c - ts[i] - 2) % DEPTH];
            end
         end
         chk("rd_waitrequest", bus.waitrequest, exp_w);
         chk("rd_valid", bus.readdatavalid, exp_v);
         if (exp_v) chk("rd_data", bus.readdata, exp_d);
         tick();
      end
      bus.read = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.address    = '0;
      bus.burstcount = 8'd1;
      bus.writedata  = '0;
      bus.byteenable = '0;
      reset_n        = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      m_wbc   = '0;
      m_err   = 1'b0;

      // Reset state
      @(negedge clock);
      chk("rst_waitrequest", bus.waitrequest, 1'b0);
      chk("rst_rdv", bus.readdatavalid, 1'b0);
      chk("rst_readdata", bus.readdata, 64'd0);
      check_status("rst");
      tick();

      // Single write then read
      wd[0] = 64'h0123_4567_89AB_CDEF; wb[0] = 8'hFF;
      wr_burst(29'h10, 8'd1, 1, 1'b0, 1'b0);
      chk("single_wbc", write_beat_count, 32'd1);
      rd_a[0] = 29'h10; rd_b[0] = 8'd1;
      read_cmds(1);

      // Fill the whole RAM so any later read has a defined model value
      for (int i = 0; i < 16; i++) begin
         wd[i] = {$urandom, $urandom};
         wb[i] = 8'hFF;
      end
      wr_burst(29'd1, 8'd16, 16, 1'b1, 1'b0);
      check_status("fill");

      // Byte enables
      wd[0] = '1;    wb[0] = 8'hFF;
      wr_burst(29'd5, 8'd1, 1, 1'b0, 1'b0);
      wd[0] = '0;    wb[0] = 8'h0F;
      wr_burst(29'd5, 8'd1, 1, 1'b0, 1'b0);
      chk("be_model", m_mem[5], 64'hFFFF_FFFF_0000_0000);
      rd_a[0] = 29'd5; rd_b[0] = 8'd1;
      read_cmds(1);

      // Burst wrapping past the top of the RAM
      for (int i = 0; i < 4; i++) begin
         wd[i] = 64'(i + 1);
         wb[i] = 8'hFF;
      end
      wr_burst(29'd14, 8'd4, 4, 1'b0, 1'b0);
      chk("wrap_model", m_mem[0], 64'd3);
      rd_a[0] = 29'd14; rd_b[0] = 8'd4;
      rd_a[1] = 29'd0;  rd_b[1] = 8'd1;
      read_cmds(2);

      // Read burst timing with a back-to-back read
      rd_a[0] = 29'($urandom); rd_b[0] = 8'd8;
      rd_a[1] = 29'($urandom); rd_b[1] = 8'd3;
      read_cmds(2);
      check_status("timing");

      // Randomized write bursts with gaps, then chained reads
      for (int it = 0; it < 8; it++) begin
         int n;
         int nr;
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            wd[i] = {$urandom, $urandom};
            wb[i] = 8'($urandom);
         end
         wr_burst(29'($urandom), 8'(n), n, 1'b1, 1'b0);
         nr = $urandom_range(1, 3);
         for (int i = 0; i < nr; i++) begin
            rd_a[i] = 29'($urandom);
            rd_b[i] = 8'($urandom_range(1, 9));
         end
         read_cmds(nr);
         check_status("rand");
      end

      // Read and write together in IDLE: write wins, read ignored
      wd[0] = 64'hDEAD_BEEF_CAFE_F00D; wb[0] = 8'hFF;
      wr_burst(29'd7, 8'd1, 1, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         chk("rw_no_rdv", bus.readdatavalid, 1'b0);
         tick();
      end
      check_status("rw");
      rd_a[0] = 29'd7; rd_b[0] = 8'd1;
      read_cmds(1);
      do_reset();
      @(negedge clock);
      check_status("rw_cleared");
      tick();

      // Zero burstcount is one beat and the flag is sticky until reset
      wd[0] = 64'h1111_2222_3333_4444; wb[0] = 8'hFF;
      wr_burst(29'd9, 8'd0, 1, 1'b0, 1'b0);
      wd[0] = 64'h5555_6666_7777_8888; wb[0] = 8'hFF;
      wr_burst(29'd10, 8'd1, 1, 1'b0, 1'b0);
      check_status("bc0");
      rd_a[0] = 29'd9; rd_b[0] = 8'd2;
      read_cmds(1);
      check_status("bc0_sticky");
      do_reset();
      @(negedge clock);
      check_status("bc0_cleared");
      tick();

      // Read raised in the middle of a write burst
      bus.write = 1'b1; bus.read = 1'b0; bus.address = 29'd3; bus.burstcount = 8'd2;
      bus.writedata = 64'hAAAA_0000_0000_0001; bus.byteenable = 8'hFF;
      tick();
      bus.write = 1'b0; bus.read = 1'b1;
      tick();
      bus.read = 1'b0; bus.write = 1'b1; bus.address = 29'd12; bus.burstcount = 8'd5;
      bus.writedata = 64'hAAAA_0000_0000_0002;
      tick();
      bus.write = 1'b0;
      m_mem[3] = 64'hAAAA_0000_0000_0001;
      m_mem[4] = 64'hAAAA_0000_0000_0002;
      m_wbc    = m_wbc + 2;
      m_err    = 1'b1;
      @(negedge clock);
      check_status("wb_read");
      tick();
      rd_a[0] = 29'd3; rd_b[0] = 8'd2;
      read_cmds(1);

      // Reset in the middle of a read burst
      bus.read = 1'b1; bus.write = 1'b0; bus.address = 29'd2; bus.burstcount = 8'd8;
      for (int c = 0; c <= 9; c++) begin
         if (c == 1) bus.read = 1'b0;
         if (c == 4) reset_n = 1'b0;
         if (c == 5) begin
            reset_n = 1'b1;
            m_wbc   = '0;
            m_err   = 1'b0;
         end
         @(negedge clock);
         chk("rstmid_waitrequest", bus.waitrequest, (c >= 1 && c <= 4));
         chk("rstmid_rdv", bus.readdatavalid, (c >= 2 && c <= 4));
         if (c >= 2 && c <= 4) chk("rstmid_data", bus.readdata, m_mem[(2 + c - 2) % DEPTH]);
         tick();
      end
      check_status("rstmid");
      rd_a[0] = 29'd2; rd_b[0] = 8'd4;
      read_cmds(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
